// File: rtl/segasys1_sndcmd_ioctl.sv
// Main-CPU I/O write decoder for SYS1/SYS2: video-mode latch plus a sound-command FIFO
// acknowledged one entry at a time by the sound CPU latch read.
module segasys1_sndcmd_ioctl #(
  parameter int unsigned DW         = 8,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned PPI_MODE   = 0
) (
  input  logic                  CLK48M,
  input  logic                  RESET,
  input  logic [4:0]            CPUAD,
  input  logic [DW-1:0]         CPUDO,
  input  logic                  IOWR,
  input  logic                  SNDRD,
  output logic [DW-1:0]         SNDDO,
  output logic                  SNDRQ,
  output logic [DW-1:0]         VIDMD,
  output logic                  FULL,
  output logic                  OVF,
  output logic [DEPTH_LOG2:0]   COUNT
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;

  localparam logic [4:0] PIO_CMD = 5'h18;
  localparam logic [4:0] PIO_VID = 5'h19;
  localparam logic [4:0] PPI_STG = 5'h10;
  localparam logic [4:0] PPI_VID = 5'h11;
  localparam logic [4:0] PPI_CTL = 5'h12;

  logic          iowr_q;
  logic          sndrd_q;
  logic [DW-1:0] vidmd;
  logic [DW-1:0] staged;
  logic          bit7hist;
  logic [PW-1:0] wrptr;
  logic [PW-1:0] rdptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          sndrq;
  logic          full;
  logic [DW-1:0] snddo;
  logic [DW-1:0] mem [DEPTH];

  logic          wr_ev_c;
  logic          pop_ev_c;
  logic          vid_we_c;
  logic          stg_we_c;
  logic          b7_we_c;
  logic          push_c;
  logic [DW-1:0] push_data_c;
  logic          full_c;
  logic          do_pop_c;
  logic          do_push_c;
  logic          ovf_set_c;
  logic [CW-1:0] count_nxt_c;
  logic [PW-1:0] rdptr_nxt_c;
  logic [DW-1:0] head_nxt_c;

  assign wr_ev_c  = IOWR & ~iowr_q;
  assign pop_ev_c = SNDRD & ~sndrd_q;

  // Address decode: one target per write event
  always_comb begin
    vid_we_c    = 1'b0;
    stg_we_c    = 1'b0;
    b7_we_c     = 1'b0;
    push_c      = 1'b0;
    push_data_c = CPUDO;
    if (wr_ev_c) begin
      if (PPI_MODE == 0) begin
        if (CPUAD == PIO_VID) vid_we_c = 1'b1;
        if (CPUAD == PIO_CMD) push_c   = 1'b1;
      end else begin
        push_data_c = staged;
        if (CPUAD == PPI_STG) stg_we_c = 1'b1;
        if (CPUAD == PPI_VID) vid_we_c = 1'b1;
        if (CPUAD == PPI_CTL) begin
          b7_we_c = 1'b1;
          push_c  = CPUDO[7] & ~bit7hist;
        end
      end
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a coincident push
  always_comb begin
    full_c      = (count == CW'(DEPTH));
    do_pop_c    = pop_ev_c & (count != '0);
    do_push_c   = push_c & (~full_c | do_pop_c);
    ovf_set_c   = push_c & full_c & ~do_pop_c;
    count_nxt_c = count + CW'(do_push_c) - CW'(do_pop_c);
    rdptr_nxt_c = rdptr + PW'(do_pop_c);
    head_nxt_c  = (do_push_c && (wrptr == rdptr_nxt_c)) ? push_data_c : mem[rdptr_nxt_c];
  end

  always_ff @(posedge CLK48M) begin
    if (do_push_c) mem[wrptr] <= push_data_c;
  end

  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      iowr_q   <= 1'b1;
      sndrd_q  <= 1'b1;
      vidmd    <= '0;
      staged   <= '0;
      bit7hist <= 1'b0;
      wrptr    <= '0;
      rdptr    <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      sndrq    <= 1'b0;
      full     <= 1'b0;
      snddo    <= '1;
    end else begin
      iowr_q  <= IOWR;
      sndrd_q <= SNDRD;
      if (vid_we_c) vidmd    <= CPUDO;
      if (stg_we_c) staged   <= CPUDO;
      if (b7_we_c)  bit7hist <= CPUDO[7];
      if (do_push_c) wrptr <= wrptr + PW'(1);
      rdptr <= rdptr_nxt_c;
      count <= count_nxt_c;
      if (ovf_set_c) ovf <= 1'b1;
      sndrq <= (count_nxt_c != '0);
      full  <= (count_nxt_c == CW'(DEPTH));
      snddo <= (count_nxt_c != '0) ? head_nxt_c : '1;
    end
  end

  assign SNDDO = snddo;
  assign SNDRQ = sndrq;
  assign VIDMD = vidmd;
  assign FULL  = full;
  assign OVF   = ovf;
  assign COUNT = count;

endmodule

// File: tb/tb_segasys1_sndcmd_ioctl.sv
// Bench for segasys1_sndcmd_ioctl: PIO and 8255 variants driven in parallel and checked
// every cycle against a list-based model, plus directed literal checks.
module tb_segasys1_sndcmd_ioctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iowr;
  logic       sndrd;
  logic [4:0] ad;
  logic [7:0] dout;

  logic [7:0] snddo0, snddo1, vid0, vid1;
  logic       rq0, rq1, full0, full1, ovf0, ovf1;
  logic [2:0] cnt0, cnt1;

  segasys1_sndcmd_ioctl #(.DW(8), .DEPTH_LOG2(2), .PPI_MODE(0)) d0 (
    .CLK48M(clk), .RESET(rst), .CPUAD(ad), .CPUDO(dout), .IOWR(iowr), .SNDRD(sndrd),
    .SNDDO(snddo0), .SNDRQ(rq0), .VIDMD(vid0), .FULL(full0), .OVF(ovf0), .COUNT(cnt0)
  );

  segasys1_sndcmd_ioctl #(.DW(8), .DEPTH_LOG2(2), .PPI_MODE(1)) d1 (
    .CLK48M(clk), .RESET(rst), .CPUAD(ad), .CPUDO(dout), .IOWR(iowr), .SNDRD(sndrd),
    .SNDDO(snddo1), .SNDRQ(rq1), .VIDMD(vid1), .FULL(full1), .OVF(ovf1), .COUNT(cnt1)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  function automatic void cmp(string nm, int m, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h at %0t", nm, m, act, exp, $time);
    end
  endfunction

  // Model: each variant keeps its queue as a plain list, head at index 0
  logic [7:0] mq [2][4];
  int         mcnt [2];
  logic [7:0] mvid [2];
  logic       movf [2];
  logic [7:0] mst;
  logic       mb7;
  logic       piowr, psndrd;
  bit         m_wr, m_pp, m_push;
  logic [7:0] m_pd;

  always @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        mcnt[m] = 0;
        mvid[m] = 8'h00;
        movf[m] = 1'b0;
      end
      mst    = 8'h00;
      mb7    = 1'b0;
      piowr  = 1'b1;
      psndrd = 1'b1;
    end else begin
      m_wr = iowr && !piowr;
      m_pp = sndrd && !psndrd;
      for (int m = 0; m < 2; m++) begin
        m_push = 1'b0;
        m_pd   = dout;
        if (m_wr) begin
          if (m == 0) begin
            if (ad == 5'h19) mvid[0] = dout;
            else if (ad == 5'h18) m_push = 1'b1;
          end else begin
            if (ad == 5'h10) mst = dout;
            else if (ad == 5'h11) mvid[1] = dout;
            else if (ad == 5'h12) begin
              m_push = dout[7] && !mb7;
              m_pd   = mst;
              mb7    = dout[7];
            end
          end
        end
        if (m_pp && mcnt[m] > 0) begin
          for (int k = 0; k < 3; k++) mq[m][k] = mq[m][k+1];
          mcnt[m]--;
        end
        if (m_push) begin
          if (mcnt[m] < 4) begin
            mq[m][mcnt[m]] = m_pd;
            mcnt[m]++;
          end else begin
            movf[m] = 1'b1;
          end
        end
      end
      piowr  = iowr;
      psndrd = sndrd;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        cmp("snddo", m, 32'(m ? snddo1 : snddo0), 32'(mcnt[m] > 0 ? mq[m][0] : 8'hFF));
        cmp("sndrq", m, 32'(m ? rq1 : rq0), 32'(mcnt[m] != 0));
        cmp("count", m, 32'(m ? cnt1 : cnt0), 32'(mcnt[m]));
        cmp("full",  m, 32'(m ? full1 : full0), 32'(mcnt[m] == 4));
        cmp("ovf",   m, 32'(m ? ovf1 : ovf0), 32'(movf[m]));
        cmp("vidmd", m, 32'(m ? vid1 : vid0), 32'(mvid[m]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    ad = a; dout = d; iowr = 1'b1;
    cyc(1);
    iowr = 1'b0;
    cyc(1);
  endtask

  task automatic pop();
    sndrd = 1'b1;
    cyc(1);
    sndrd = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst = 1'b1; iowr = 1'b0; sndrd = 1'b0; ad = 5'h00; dout = 8'h00;
    cyc(2);
    chk_en = 1'b1;
    cmp("rst_count", 0, 32'(cnt0), 32'd0);
    cmp("rst_vid",   1, 32'(vid1), 32'd0);
    cmp("rst_snddo", 0, 32'(snddo0), 32'hFF);
    rst = 1'b0;
    cyc(1);

    // Long strobe yields one VIDMD write only
    ad = 5'h19; dout = 8'hA5; iowr = 1'b1;
    cyc(1);
    cmp("vid_first", 0, 32'(vid0), 32'hA5);
    dout = 8'h3C;
    cyc(15);
    cmp("vid_hold", 0, 32'(vid0), 32'hA5);
    cmp("vid_cnt", 0, 32'(cnt0), 32'd0);
    iowr = 1'b0;
    cyc(1);

    // Three commands in order
    wr(5'h18, 8'h11);
    cmp("rq_first", 0, 32'(rq0), 32'd1);
    cmp("head_11", 0, 32'(snddo0), 32'h11);
    wr(5'h18, 8'h22);
    wr(5'h18, 8'h33);
    cmp("cnt_3", 0, 32'(cnt0), 32'd3);
    pop();
    cmp("head_22", 0, 32'(snddo0), 32'h22);
    pop();
    cmp("head_33", 0, 32'(snddo0), 32'h33);
    pop();
    cmp("rq_empty", 0, 32'(rq0), 32'd0);
    cmp("snddo_ff", 0, 32'(snddo0), 32'hFF);

    // Overflow
    for (int i = 1; i <= 5; i++) begin
      wr(5'h18, 8'(i));
      if (i == 4) cmp("full_4", 0, 32'(full0), 32'd1);
    end
    cmp("ovf_set", 0, 32'(ovf0), 32'd1);
    cmp("cnt_sat", 0, 32'(cnt0), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      cmp("ovf_order", 0, 32'(snddo0), 32'(i));
      pop();
    end
    cmp("ovf_sticky", 0, 32'(ovf0), 32'd1);
    rst = 1'b1; cyc(1); rst = 1'b0; cyc(1);
    cmp("ovf_clr", 0, 32'(ovf0), 32'd0);

    // 8255 staged push on bit7 rising
    wr(5'h10, 8'h5C);
    wr(5'h12, 8'h00);
    wr(5'h12, 8'h80);
    cmp("ppi_cnt1", 1, 32'(cnt1), 32'd1);
    cmp("ppi_5c", 1, 32'(snddo1), 32'h5C);
    wr(5'h12, 8'h80);
    cmp("ppi_norepush", 1, 32'(cnt1), 32'd1);
    wr(5'h12, 8'h00);
    wr(5'h10, 8'h77);
    wr(5'h12, 8'h80);
    pop();
    cmp("ppi_77", 1, 32'(snddo1), 32'h77);
    pop();
    cmp("ppi_empty", 1, 32'(cnt1), 32'd0);

    // Full with coincident push and pop
    for (int i = 1; i <= 4; i++) wr(5'h18, 8'(8'hA0 + i));
    cmp("full_pre", 0, 32'(full0), 32'd1);
    ad = 5'h18; dout = 8'hAA; iowr = 1'b1; sndrd = 1'b1;
    cyc(1);
    cmp("sim_cnt", 0, 32'(cnt0), 32'd4);
    cmp("sim_head", 0, 32'(snddo0), 32'hA2);
    cmp("sim_ovf", 0, 32'(ovf0), 32'd0);
    iowr = 1'b0; sndrd = 1'b0;
    cyc(1);
    pop(); pop(); pop();
    cmp("sim_tail", 0, 32'(snddo0), 32'hAA);
    pop();
    ad = 5'h18; dout = 8'h5A; iowr = 1'b1; sndrd = 1'b1;
    cyc(1);
    cmp("sim0_cnt", 0, 32'(cnt0), 32'd1);
    cmp("sim0_head", 0, 32'(snddo0), 32'h5A);
    iowr = 1'b0; sndrd = 1'b0;
    cyc(1);

    // Reset with strobe held high
    wr(5'h18, 8'hB1);
    ad = 5'h18; dout = 8'hC3; iowr = 1'b1; rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    cmp("rh_cnt", 0, 32'(cnt0), 32'd0);
    cmp("rh_rq", 0, 32'(rq0), 32'd0);
    cmp("rh_vid", 0, 32'(vid0), 32'd0);
    iowr = 1'b0;
    cyc(1);
    cmp("rh_nopush", 0, 32'(cnt0), 32'd0);
    iowr = 1'b1;
    cyc(1);
    cmp("rh_push", 0, 32'(cnt0), 32'd1);
    cmp("rh_head", 0, 32'(snddo0), 32'hC3);
    iowr = 1'b0;
    cyc(1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) iowr = ~iowr;
      if ($urandom_range(0, 2) == 0) sndrd = ~sndrd;
      case ($urandom_range(0, 5))
        0: ad = 5'h18;
        1: ad = 5'h19;
        2: ad = 5'h10;
        3: ad = 5'h11;
        4: ad = 5'h12;
        default: ad = 5'($urandom_range(0, 31));
      endcase
      dout = 8'($urandom_range(0, 255));
      cyc(1);
    end
    rst = 1'b0; iowr = 1'b0; sndrd = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
